// File: rtl/frog_bus_mem.sv
// -----------------------------------------------------------------------------
// frog_bus_mem
//   128 x 4-bit nibble memory sitting on a 7-bit multiplexed CPU bus, with a
//   host-side sequential preload port.
//
//   CPU side: a write is a strobe of at least two cycles. The first cycle
//   carries the address and the second carries the data nibble in
//   cpu_bus[3:0]. Any further strobe cycles are ignored. A one-cycle strobe
//   aborts without writing. Reads are combinational. cpu_data returns NOP
//   (4'h8) while a write strobe is high or while a preload is running.
//
//   Loader side: raising load_en starts a preload at address 0. Each
//   load_valid cycle stores load_nib and advances the pointer modulo 128.
//   CPU writes are suppressed while the preload runs.
//
//   Optional feature: define FROG_MEM_WRPROT_EN to make 7'h00-7'h3F
//   read-only to the CPU. Dropped writes set the sticky prot_hit flag.
//   Preload writes are not affected.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   cpu_bus    in   [6:0] CPU address / write data
//   cpu_wcyc   in   CPU write-cycle strobe (0 = read)
//   cpu_data   out  [3:0] read nibble
//   load_en    in   preload mode enable
//   load_valid in   load_nib valid
//   load_nib   in   [3:0] preload nibble
//   load_ptr   out  [6:0] next preload address
//   load_wrap  out  sticky: preload pointer wrapped past 7'h7F
//   prot_hit   out  sticky: protected CPU write dropped (0 without macro)
// -----------------------------------------------------------------------------
module frog_bus_mem #(
  parameter int MEM_DEPTH = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] cpu_bus,
  input  logic       cpu_wcyc,
  output logic [3:0] cpu_data,
  input  logic       load_en,
  input  logic       load_valid,
  input  logic [3:0] load_nib,
  output logic [6:0] load_ptr,
  output logic       load_wrap,
  output logic       prot_hit
);

  localparam logic [3:0] NOP = 4'h8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_HOLD} wr_state_t;
  typedef enum logic       {L_IDLE, L_LOAD}         ld_state_t;

  wr_state_t  wr_state_reg, wr_state_next;
  logic [6:0] wr_addr_reg, wr_addr_next;
  ld_state_t  ld_state_reg, ld_state_next;
  logic [6:0] load_ptr_reg, load_ptr_next;
  logic       load_wrap_reg, load_wrap_next;

  logic       cpu_commit;   // write FSM reached its data cycle
  logic       prot_drop;    // ... but the target is protected
  logic       cpu_we;
  logic       ld_we;

  logic       mem_we;
  logic [6:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [MEM_DEPTH-1:0] loc_we;

  // Every location resets to NOP, so storage is a flop array rather than RAM.
  logic [3:0] mem_reg [MEM_DEPTH];

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_reg <= W_IDLE;
      wr_addr_reg  <= 7'h00;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_addr_reg  <= wr_addr_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_addr_next  = wr_addr_reg;
    cpu_commit    = 1'b0;
    if (ld_state_reg == L_LOAD) begin
      // A running preload owns the memory. The CPU write sequence restarts.
      wr_state_next = W_IDLE;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (cpu_wcyc) begin
            wr_addr_next  = cpu_bus;
            wr_state_next = W_ADDR;
          end
        end
        W_ADDR: begin
          if (cpu_wcyc) begin
            cpu_commit    = 1'b1;
            wr_state_next = W_HOLD;
          end else begin
            wr_state_next = W_IDLE;
          end
        end
        W_HOLD: begin
          if (!cpu_wcyc) wr_state_next = W_IDLE;
        end
        default: wr_state_next = W_IDLE;
      endcase
    end
  end

`ifdef FROG_MEM_WRPROT_EN
  logic prot_hit_reg;

  // Lower half of the address space is read-only to the CPU.
  assign prot_drop = cpu_commit && !wr_addr_reg[6];

  always_ff @(posedge clk) begin
    if (!rst_n)         prot_hit_reg <= 1'b0;
    else if (prot_drop) prot_hit_reg <= 1'b1;
  end

  assign prot_hit = prot_hit_reg;
`else
  assign prot_drop = 1'b0;
  assign prot_hit  = 1'b0;
`endif

  assign cpu_we = cpu_commit && !prot_drop;

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_state_reg  <= L_IDLE;
      load_ptr_reg  <= 7'h00;
      load_wrap_reg <= 1'b0;
    end else begin
      ld_state_reg  <= ld_state_next;
      load_ptr_reg  <= load_ptr_next;
      load_wrap_reg <= load_wrap_next;
    end
  end

  always_comb begin
    ld_state_next  = ld_state_reg;
    load_ptr_next  = load_ptr_reg;
    load_wrap_next = load_wrap_reg;
    ld_we          = 1'b0;
    case (ld_state_reg)
      L_IDLE: begin
        // load_valid in the entering cycle is deliberately ignored.
        if (load_en) begin
          ld_state_next  = L_LOAD;
          load_ptr_next  = 7'h00;
          load_wrap_next = 1'b0;
        end
      end
      L_LOAD: begin
        if (!load_en) begin
          ld_state_next = L_IDLE;
        end else if (load_valid) begin
          ld_we         = 1'b1;
          load_ptr_next = load_ptr_reg + 7'd1;
          if (load_ptr_reg == 7'h7F) load_wrap_next = 1'b1;
        end
      end
      default: ld_state_next = L_IDLE;
    endcase
  end

  assign load_ptr  = load_ptr_reg;
  assign load_wrap = load_wrap_reg;

  // ---------------------------------------------------------------------------
  // Storage. Loader and CPU writes are mutually exclusive because cpu_commit
  // is suppressed while the loader is in L_LOAD.
  // ---------------------------------------------------------------------------
  assign mem_we    = ld_we || cpu_we;
  assign mem_addr  = ld_we ? load_ptr_reg : wr_addr_reg;
  assign mem_wdata = ld_we ? load_nib     : cpu_bus[3:0];

  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_loc_we
    assign loc_we[gi] = mem_we && (mem_addr == 7'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_reg[i] <= NOP;
    end else begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        if (loc_we[i]) mem_reg[i] <= mem_wdata;
      end
    end
  end

  assign cpu_data = (cpu_wcyc || (ld_state_reg == L_LOAD)) ? NOP : mem_reg[cpu_bus];

endmodule

// File: tb/tb_frog_bus_mem.sv
// -----------------------------------------------------------------------------
// tb_frog_bus_mem
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A behavioural model of the memory checks every cycle after the
//   first reset. The model describes CPU writes as "address on the first
//   strobe cycle, data on the second", not as a state machine.
// -----------------------------------------------------------------------------
module tb_frog_bus_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] cpu_bus;
  logic       cpu_wcyc;
  logic [3:0] cpu_data;
  logic       load_en;
  logic       load_valid;
  logic [3:0] load_nib;
  logic [6:0] load_ptr;
  logic       load_wrap;
  logic       prot_hit;

  always #5 clk = ~clk;

  frog_bus_mem #(.MEM_DEPTH(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_bus    (cpu_bus),
    .cpu_wcyc   (cpu_wcyc),
    .cpu_data   (cpu_data),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_nib   (load_nib),
    .load_ptr   (load_ptr),
    .load_wrap  (load_wrap),
    .prot_hit   (prot_hit)
  );

`ifdef FROG_MEM_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [3:0] m_mem [128];
  int         m_run   = 0;      // consecutive strobe cycles in the current write
  logic [6:0] m_waddr = 7'h00;
  bit         m_ld    = 1'b0;
  int         m_ptr   = 0;
  bit         m_wrap  = 1'b0;
  bit         m_prot  = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) m_mem[i] = 4'h8;
      m_run   = 0;
      m_ld    = 1'b0;
      m_ptr   = 0;
      m_wrap  = 1'b0;
      m_prot  = 1'b0;
      m_valid = 1'b1;
    end else begin
      // CPU write: address on strobe cycle 1, data on strobe cycle 2.
      if (m_ld || !cpu_wcyc) begin
        m_run = 0;
      end else begin
        if (m_run == 0) begin
          m_waddr = cpu_bus;
        end else if (m_run == 1) begin
          if (PROT && m_waddr < 7'd64) m_prot = 1'b1;
          else                         m_mem[m_waddr] = cpu_bus[3:0];
        end
        if (m_run < 2) m_run++;
      end
      // Preload.
      if (!m_ld) begin
        if (load_en) begin
          m_ld   = 1'b1;
          m_ptr  = 0;
          m_wrap = 1'b0;
        end
      end else if (!load_en) begin
        m_ld = 1'b0;
      end else if (load_valid) begin
        m_mem[m_ptr] = load_nib;
        if (m_ptr == 127) m_wrap = 1'b1;
        m_ptr = (m_ptr + 1) % 128;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_cpu_data", 32'(cpu_data), 32'((cpu_wcyc || m_ld) ? 4'h8 : m_mem[cpu_bus]));
      check("model_load_ptr", 32'(load_ptr), 32'(m_ptr));
      check("model_load_wrap", 32'(load_wrap), 32'(m_wrap));
      check("model_prot_hit", 32'(prot_hit), 32'(m_prot));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input bit r, input logic [6:0] b, input bit w,
                      input bit le, input bit lv, input logic [3:0] nb);
    rst_n      = r;
    cpu_bus    = b;
    cpu_wcyc   = w;
    load_en    = le;
    load_valid = lv;
    load_nib   = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [6:0] b, input logic [3:0] exp, input string nm);
    rst_n      = 1'b1;
    cpu_bus    = b;
    cpu_wcyc   = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check(nm, 32'(cpu_data), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  logic [3:0] stream [5];
  logic [3:0] nib_first2;
  logic [3:0] nib_last;
  logic [3:0] nb;
  bit         le;

  initial begin
    stream[0] = 4'h8; stream[1] = 4'h8; stream[2] = 4'hC;
    stream[3] = 4'h0; stream[4] = 4'hD;
    nib_first2 = 4'h0;
    nib_last   = 4'h0;

    // Reset, then a read of 7'h05.
    step(1'b0, 7'h05, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 7'h05, 1'b0, 1'b0, 1'b0, 4'h0);
    check("reset_load_ptr", 32'(load_ptr), 32'h0);
    check("reset_load_wrap", 32'(load_wrap), 32'h0);
    check("reset_prot_hit", 32'(prot_hit), 32'h0);
    peek(7'h05, 4'h8, "reset_read_05");

    // Short preload of five nibbles.
    step(1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 4'hF);   // entering cycle, valid ignored
    for (int i = 0; i < 5; i++) step(1'b1, 7'h00, 1'b0, 1'b1, 1'b1, stream[i]);
    step(1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 4'h0);
    peek(7'h00, 4'h8, "preload_read_00");
    peek(7'h02, 4'hC, "preload_read_02");
    peek(7'h04, 4'hD, "preload_read_04");
    check("preload_ptr", 32'(load_ptr), 32'h05);

    // Two-cycle write commits, a one-cycle strobe aborts.
    step(1'b1, 7'h50, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 7'h07, 1'b1, 1'b0, 1'b0, 4'h0);
    peek(7'h50, 4'h7, "write_read_50");
    step(1'b1, 7'h51, 1'b1, 1'b0, 1'b0, 4'h0);
    peek(7'h51, 4'h8, "abort_read_51");
    peek(7'h51, 4'h8, "abort_read_51_again");

    // Write into the low half. The result depends on write protection.
    step(1'b1, 7'h20, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 7'h03, 1'b1, 1'b0, 1'b0, 4'h0);
    peek(7'h20, PROT ? 4'h8 : 4'h3, "prot_read_20");
    check("prot_hit_flag", 32'(prot_hit), 32'(PROT));

    // Reset during the data cycle of a write to 7'h60.
    step(1'b1, 7'h60, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 7'h07, 1'b1, 1'b0, 1'b0, 4'h0);
    peek(7'h60, 4'h8, "rst_mid_write_60");
    step(1'b1, 7'h61, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 7'h05, 1'b1, 1'b0, 1'b0, 4'h0);
    peek(7'h61, 4'h5, "post_rst_write_61");

    // 129-nibble preload wraps the pointer.
    step(1'b1, 7'h00, 1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 1; i <= 129; i++) begin
      nb = 4'($urandom);
      if (i == 2)   nib_first2 = nb;
      if (i == 129) nib_last   = nb;
      step(1'b1, 7'h00, 1'b0, 1'b1, 1'b1, nb);
    end
    step(1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 4'h0);
    check("wrap_flag", 32'(load_wrap), 32'h1);
    check("wrap_ptr", 32'(load_ptr), 32'h01);
    peek(7'h00, nib_last, "wrap_read_00");
    peek(7'h01, nib_first2, "wrap_read_01");
    check("wrap_flag_held", 32'(load_wrap), 32'h1);

    // Starting a new preload clears the wrap flag and the pointer.
    step(1'b1, 7'h01, 1'b0, 1'b1, 1'b0, 4'h0);
    check("reload_wrap_clear", 32'(load_wrap), 32'h0);
    check("reload_ptr_zero", 32'(load_ptr), 32'h0);
    check("reload_nop_read", 32'(cpu_data), 32'h8);
    step(1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 4'h0);

    // Randomized traffic.
    le = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) le = !le;
      step($urandom_range(0, 199) != 0, 7'($urandom), $urandom_range(0, 2) != 0,
           le, 1'($urandom_range(0, 1)), 4'($urandom));
    end
    step(1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
